// File: rtl/ram_loader_if.sv
// ram_loader_if: control, data-stream and RAM-side signals of the RAM loader.
// master = driver/CPU side, slave = loader side; the tri-state data bus stays a separate port.
interface ram_loader_if;
    logic       start;
    logic [3:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] addr;
    logic       ram_write;
    logic       ram_read;
    logic       busy;
    logic       done;
    logic       pass;

    modport master (
        output start, len, in_data, in_valid,
        input  in_ready, addr, ram_write, ram_read, busy, done, pass
    );

    modport slave (
        input  start, len, in_data, in_valid,
        output in_ready, addr, ram_write, ram_read, busy, done, pass
    );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: writes len+1 streamed bytes into RAM over a shared tri-state bus and,
// when VERIFY=1, reads them back and compares mod-256 byte sums.
// Ports: clk, rst (sync active-high), io (ram_loader_if.slave), bus (8-bit inout).
module ram_loader #(
    parameter bit VERIFY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    ram_loader_if.slave io,
    inout  wire  [7:0]  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RD1, RD2, DONE} state_t;

    state_t     state;
    logic [3:0] mar;
    logic [3:0] last;
    logic [7:0] hold;
    logic [7:0] wsum;
    logic [7:0] rsum;
    logic       result;
    logic [4:0] ctl;
    logic [7:0] rsum_next;

    // {in_ready, ram_write, ram_read, busy, done} for a given state
    function automatic logic [4:0] decode(state_t s);
        logic [4:0] d;
        d = 5'b00000;
        case (s)
            LOAD:    d = 5'b10010;
            WRITE:   d = 5'b01010;
            RD1:     d = 5'b00110;
            RD2:     d = 5'b00110;
            DONE:    d = 5'b00011;
            default: d = 5'b00000;
        endcase
        return d;
    endfunction

    assign rsum_next = rsum + bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ctl    <= decode(IDLE);
            mar    <= 4'd0;
            last   <= 4'd0;
            hold   <= 8'd0;
            wsum   <= 8'd0;
            rsum   <= 8'd0;
            result <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io.start) begin
                        state  <= LOAD;
                        ctl    <= decode(LOAD);
                        mar    <= 4'd0;
                        last   <= io.len;
                        wsum   <= 8'd0;
                        rsum   <= 8'd0;
                        result <= 1'b0;
                    end
                end
                LOAD: begin
                    if (io.in_valid) begin
                        hold  <= io.in_data;
                        wsum  <= wsum + io.in_data;
                        state <= WRITE;
                        ctl   <= decode(WRITE);
                    end
                end
                WRITE: begin
                    if (mar != last) begin
                        mar   <= mar + 4'd1;
                        state <= LOAD;
                        ctl   <= decode(LOAD);
                    end else if (VERIFY) begin
                        mar   <= 4'd0;
                        state <= RD1;
                        ctl   <= decode(RD1);
                    end else begin
                        result <= 1'b1;
                        state  <= DONE;
                        ctl    <= decode(DONE);
                    end
                end
                RD1: begin
                    // RAM output is stale here; bus is only sampled in RD2
                    state <= RD2;
                    ctl   <= decode(RD2);
                end
                RD2: begin
                    rsum <= rsum_next;
                    if (mar != last) begin
                        mar   <= mar + 4'd1;
                        state <= RD1;
                        ctl   <= decode(RD1);
                    end else begin
                        // compare on entry so pass is already valid alongside done
                        result <= (rsum_next == wsum);
                        state  <= DONE;
                        ctl    <= decode(DONE);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ctl   <= decode(IDLE);
                end
                default: begin
                    state <= IDLE;
                    ctl   <= decode(IDLE);
                end
            endcase
        end
    end

    assign io.in_ready  = ctl[4];
    assign io.ram_write = ctl[3];
    assign io.ram_read  = ctl[2];
    assign io.busy      = ctl[1];
    assign io.done      = ctl[0];
    assign io.addr      = mar;
    assign io.pass      = result;

    assign bus = ctl[3] ? hold : 8'hzz;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: table-driven and randomized check of ram_loader (VERIFY=1 and VERIFY=0)
// against a behavioural RAM and a transaction-level expectation model.
module tb_ram_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sel;
    logic start_d;
    logic [3:0] len_d;
    logic [7:0] data_d;
    logic valid_d;
    logic cor_en;
    logic [3:0] cor_a;

    ram_loader_if ifv();
    ram_loader_if ifn();
    wire [7:0] bus_v;
    wire [7:0] bus_n;

    assign ifv.start    = start_d & sel;
    assign ifn.start    = start_d & ~sel;
    assign ifv.len      = len_d;
    assign ifn.len      = len_d;
    assign ifv.in_data  = data_d;
    assign ifn.in_data  = data_d;
    assign ifv.in_valid = valid_d;
    assign ifn.in_valid = valid_d;

    ram_loader #(.VERIFY(1'b1)) dut_v (.clk(clk), .rst(rst), .io(ifv), .bus(bus_v));
    ram_loader #(.VERIFY(1'b0)) dut_n (.clk(clk), .rst(rst), .io(ifn), .bus(bus_n));

    // behavioural RAMs: write on strobe, registered read, optional corrupted address
    logic [7:0] mem_v [16];
    logic [7:0] mem_n [16];
    logic [7:0] q_v;
    logic [7:0] q_n;

    always @(posedge clk) begin
        if (ifv.ram_write) mem_v[ifv.addr] <= bus_v;
        if (ifv.ram_read)
            q_v <= (cor_en && ifv.addr == cor_a) ? 8'hFF : mem_v[ifv.addr];
        if (ifn.ram_write) mem_n[ifn.addr] <= bus_n;
        if (ifn.ram_read)
            q_n <= (cor_en && ifn.addr == cor_a) ? 8'hFF : mem_n[ifn.addr];
    end

    assign bus_v = ifv.ram_read ? q_v : 8'hzz;
    assign bus_n = ifn.ram_read ? q_n : 8'hzz;

    wire       rdy  = sel ? ifv.in_ready  : ifn.in_ready;
    wire       wr   = sel ? ifv.ram_write : ifn.ram_write;
    wire       rd   = sel ? ifv.ram_read  : ifn.ram_read;
    wire       bsy  = sel ? ifv.busy      : ifn.busy;
    wire       dn   = sel ? ifv.done      : ifn.done;
    wire       ps   = sel ? ifv.pass      : ifn.pass;
    wire [3:0] ad   = sel ? ifv.addr      : ifn.addr;
    wire [7:0] bs   = sel ? bus_v         : bus_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] dat [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mem_at(input int a);
        return sel ? mem_v[a] : mem_n[a];
    endfunction

    // One complete load; expectations come from the byte list and the
    // 2-cycles-per-byte throughput rule, never from DUT state.
    task automatic run(input bit v, input int len, input int st_idx, input int st_n,
                       input bit rnd_stall, input bit glitch, input int cor,
                       input int tab_done, input int tab_pass);
        int stalls = 0;
        int st_here = 0;
        int bidx = 0;
        int wcnt = 0;
        int rcnt = 0;
        int bcnt = 0;
        int done_at = 0;
        int cyc = 0;
        int exp_done;
        logic [7:0] ws;
        logic [7:0] rs;
        logic exp_pass;

        sel = v;
        cor_en = (cor >= 0);
        cor_a = 4'(cor);
        len_d = 4'(len);
        start_d = 1'b1;
        valid_d = 1'b0;
        tick();
        start_d = 1'b0;
        while (done_at == 0 && cyc < 400) begin
            cyc++;
            if (cyc == 1) check("pass_cleared", ps, 0);
            if (bsy) bcnt++;
            check("rw_exclusive", wr & rd, 0);
            if (wr) begin
                check("wr_addr", ad, wcnt);
                check("wr_data", bs, dat[wcnt % 16]);
                wcnt++;
            end
            if (rd) rcnt++;
            if (dn) done_at = cyc;
            start_d = glitch && cyc == 2;
            len_d = (glitch && cyc == 2) ? ~4'(len) : 4'(len);
            if (rdy) begin
                if ((bidx == st_idx && st_here < st_n) ||
                    (rnd_stall && $urandom_range(0, 2) == 0)) begin
                    valid_d = 1'b0;
                    stalls++;
                    if (bidx == st_idx) st_here++;
                end else begin
                    valid_d = 1'b1;
                    data_d = dat[bidx % 16];
                    bidx++;
                end
            end else begin
                valid_d = 1'($urandom_range(0, 1));
                data_d = 8'($urandom);
            end
            tick();
        end
        valid_d = 1'b0;
        start_d = 1'b0;
        if (done_at == 0) check("done_timeout", 0, 1);

        ws = 8'd0;
        rs = 8'd0;
        for (int i = 0; i <= len; i++) begin
            ws = ws + dat[i];
            rs = rs + ((i == cor) ? 8'hFF : dat[i]);
        end
        exp_pass = v ? (ws == rs) : 1'b1;
        exp_done = 2 * (len + 1) + stalls + (v ? 2 * (len + 1) : 0) + 1;

        check("done_cycle", done_at, exp_done);
        if (tab_done > 0) check("done_cycle_tab", done_at, tab_done);
        check("busy_cycles", bcnt, exp_done);
        check("write_count", wcnt, len + 1);
        check("read_count", rcnt, v ? 2 * (len + 1) : 0);
        check("done_width", dn, 0);
        check("busy_idle", bsy, 0);
        check("pass", ps, exp_pass);
        if (tab_pass >= 0) check("pass_tab", ps, tab_pass);
        for (int i = 0; i <= len; i++) check("ram_content", mem_at(i), dat[i]);
        repeat (3) tick();
        check("pass_hold", ps, exp_pass);
    endtask

    typedef struct {
        bit v;
        int len;
        int pat;
        int st_idx;
        int st_n;
        bit glitch;
        int cor;
        int exp_done;
        int exp_pass;
    } row_t;

    row_t tab [8];

    initial begin
        tab[0] = '{1'b1, 1,  2, -1, 0, 1'b0, -1, 9,  1};
        tab[1] = '{1'b1, 15, 1, -1, 0, 1'b0, -1, 65, 1};
        tab[2] = '{1'b1, 3,  0, 2,  5, 1'b0, -1, 22, 1};
        tab[3] = '{1'b1, 2,  0, -1, 0, 1'b0, 1,  13, 0};
        tab[4] = '{1'b0, 0,  3, -1, 0, 1'b0, -1, 3,  1};
        tab[5] = '{1'b1, 0,  0, -1, 0, 1'b1, -1, 5,  1};
        tab[6] = '{1'b0, 15, 0, -1, 0, 1'b1, -1, 33, 1};
        tab[7] = '{1'b1, 7,  0, 0,  3, 1'b0, -1, 36, 1};

        rst = 1'b1;
        sel = 1'b1;
        start_d = 1'b0;
        len_d = 4'd0;
        data_d = 8'd0;
        valid_d = 1'b0;
        cor_en = 1'b0;
        cor_a = 4'd0;
        repeat (2) tick();
        check("rst_state_v", {ifv.in_ready, ifv.ram_write, ifv.ram_read,
                              ifv.busy, ifv.done, ifv.pass, ifv.addr}, 0);
        check("rst_state_n", {ifn.in_ready, ifn.ram_write, ifn.ram_read,
                              ifn.busy, ifn.done, ifn.pass, ifn.addr}, 0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                case (tab[r].pat)
                    1:       dat[i] = 8'(i);
                    2:       dat[i] = (i == 0) ? 8'h11 : 8'h23;
                    3:       dat[i] = 8'hA5;
                    default: dat[i] = 8'($urandom);
                endcase
            end
            if (tab[r].cor >= 0 && dat[tab[r].cor] == 8'hFF) dat[tab[r].cor] = 8'h5A;
            run(tab[r].v, tab[r].len, tab[r].st_idx, tab[r].st_n, 1'b0,
                tab[r].glitch, tab[r].cor, tab[r].exp_done, tab[r].exp_pass);
        end

        // reset priority over start
        sel = 1'b1;
        rst = 1'b1;
        start_d = 1'b1;
        tick();
        rst = 1'b0;
        start_d = 1'b0;
        check("rst_over_start", ifv.busy, 0);

        // reset in the WRITE cycle of byte 2 of a len=7 load
        for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
        cor_en = 1'b0;
        len_d = 4'd7;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        begin
            int guard = 0;
            int idx = 0;
            while (!(ifv.ram_write && ifv.addr == 4'd2) && guard < 50) begin
                if (ifv.in_ready) begin
                    valid_d = 1'b1;
                    data_d = dat[idx % 16];
                    idx++;
                end
                guard++;
                tick();
            end
            if (guard >= 50) check("rst_wait_timeout", 0, 1);
        end
        valid_d = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {ifv.in_ready, ifv.ram_write, ifv.ram_read,
                                ifv.busy, ifv.done, ifv.pass, ifv.addr}, 0);
        check("abort_ram0", mem_v[0], dat[0]);
        check("abort_ram1", mem_v[1], dat[1]);
        tick();
        check("abort_idle", ifv.busy, 0);
        for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
        run(1'b1, 7, -1, 0, 1'b0, 1'b0, -1, 33, 1);

        // randomized loads with random stalls and occasional readback corruption
        for (int k = 0; k < 20; k++) begin
            int l;
            int c;
            l = int'($urandom_range(0, 15));
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l)) : -1;
            for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
            run(1'($urandom_range(0, 1)), l, -1, 0, 1'b1, 1'($urandom_range(0, 1)),
                c, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter VERIFY, default 1: 1 = read back and checksum after load; 0 = skip readback.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-005 len  input  4  index of last address to load (bytes = len+1); sampled with start.
REQ-006 in_data  input  8  byte to be written.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 addr  output  4  RAM address, MAR-equivalent.
REQ-010 ram_write  output  1  RAM write strobe.
REQ-011 ram_read  output  1  RAM read enable.
REQ-012 bus  inout  8  shared data bus; driven only while ram_write=1, else high-Z.
REQ-013 busy  output  1  high in every state except IDLE; CPU control holds off bus use while high.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  checksum result; valid from done until next accepted start.

Function
REQ-016 Moore FSM, states IDLE, LOAD, WRITE, RD1, RD2, DONE; in_ready, ram_write, ram_read, busy, done decoded from state only.
REQ-017 IDLE: start=1 -> LOAD; addr<=0, last<=len, wsum<=0, rsum<=0, pass<=0. Otherwise stay in IDLE.
REQ-018 start outside IDLE is ignored, with no effect on state or registers.
REQ-019 LOAD: in_ready=1; in_valid=1 -> capture in_data into hold register, wsum<=wsum+in_data (mod 256), go to WRITE; in_valid=0 -> stay in LOAD (unbounded stall).
REQ-020 WRITE: ram_write=1, bus=hold register, addr stable; RAM stores on the closing edge.
REQ-021 WRITE exit: addr!=last -> addr<=addr+1, go to LOAD; addr==last and VERIFY=1 -> addr<=0, go to RD1; addr==last and VERIFY=0 -> go to DONE.
REQ-022 RD1: ram_read=1, bus not driven; go to RD2. RAM registers memory[addr] on this edge.
REQ-023 RD2: ram_read=1; on closing edge rsum<=rsum+bus (mod 256); addr!=last -> addr<=addr+1, go to RD1; addr==last -> go to DONE.
REQ-024 Bus is never sampled in RD1; the RAM output in RD1 is stale by definition.
REQ-025 DONE: done=1 for exactly one cycle; pass<=(rsum==wsum) if VERIFY=1, else pass<=1; go to IDLE.
REQ-026 ram_read and ram_write are never high in the same cycle, and the bus is never driven while ram_read=1.
REQ-027 len=15 loads all 16 addresses; addr wraps only by reset/start, never by increment past last.
REQ-028 Throughput with in_valid held high: 2 cycles per byte load, 2 cycles per byte verify.

Reset
REQ-029 rst=1 at any edge forces IDLE, addr=0, in_ready=0, ram_write=0, ram_read=0, busy=0, done=0, pass=0, wsum=rsum=0, bus high-Z; rst takes priority over start.
REQ-030 Reset during any state aborts the load; RAM contents already written are not restored.

Verification
REQ-031 len=1, start, in_data 0x11 then 0x23 with in_valid held high, VERIFY=1, behavioural RAM model -> RAM[0]=0x11, RAM[1]=0x23, wsum=rsum=0x34, done pulse 9 cycles after start edge, pass=1.
REQ-032 len=15, bytes 0x00..0x0F, in_valid continuous -> 16 ram_write pulses at addr 0..15, done exactly 65 cycles after start edge, pass=1, busy high for 65 cycles.
REQ-033 len=3, in_valid dropped for 5 cycles before byte 2 -> FSM held in LOAD, no ram_write during stall, final RAM[0..3] correct, pass=1.
REQ-034 len=2, RAM model returns 0xFF instead of stored byte at addr 1 during readback -> done pulses, pass=0.
REQ-035 rst asserted in the WRITE cycle of byte 2 of a len=7 load -> next cycle: IDLE, all outputs 0, bus Z; a new start then completes normally with pass=1.
REQ-036 VERIFY=0, len=0, byte 0xA5 -> one ram_write at addr 0, no ram_read ever, done 3 cycles after start edge, pass=1.
